// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator: mode codes, burst states
// and the prescaler divide helper.
package led_pattern_pkg;

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_ON      = 3'd1;
  localparam logic [2:0] MODE_BLINK   = 3'd2;
  localparam logic [2:0] MODE_BURST   = 3'd3;
  localparam logic [2:0] MODE_BREATHE = 3'd4;

  typedef enum logic [1:0] {
    B_ON  = 2'd0,
    B_OFF = 2'd1,
    B_GAP = 2'd2
  } burst_state_t;

  localparam int unsigned DEFAULT_CLK_FREQ_HZ = 50000000;
  localparam int unsigned TICK_DIV = DEFAULT_CLK_FREQ_HZ / 1000;

  // Clocks per 1 ms tick; never below one so tiny test clocks still tick.
  function automatic int unsigned tick_div(input int unsigned clk_freq_hz);
    return (clk_freq_hz / 1000 < 1) ? 1 : clk_freq_hz / 1000;
  endfunction

  function automatic logic [2:0] decode_mode(input logic [2:0] m);
    return (m > MODE_BREATHE) ? MODE_OFF : m;
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Configuration write port for the LED pattern generator.
interface led_pattern_gen_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            we;
  logic [CH_W-1:0] ch;
  logic [2:0]      mode;
  logic [15:0]     period_ms;
  logic [3:0]      count;

  modport master (output we, ch, mode, period_ms, count);
  modport slave  (input  we, ch, mode, period_ms, count);

endinterface

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: latched config, phase counter, burst FSM, breathe ramp
// and the registered LED output.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                we,
  input  logic [2:0]          mode,
  input  logic [15:0]         period,
  input  logic [3:0]          count,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);

  logic [2:0]          mode_q, mode_d;
  logic [15:0]         period_q, period_d;
  logic [3:0]          count_q, count_d;
  logic [17:0]         phase_q, phase_d;
  logic [3:0]          flash_q, flash_d;
  burst_state_t        bstate_q, bstate_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_up_q, dir_up_d;
  logic                led_q, led_d;
  logic [17:0]         limit;
  logic                at_limit;

  // The gap lasts four periods; 18 bits keep 4*P from overflowing.
  assign limit = (mode_q == MODE_BURST && bstate_q == B_GAP) ?
                 {period_q, 2'b00} - 18'd1 : {2'b00, period_q} - 18'd1;
  assign at_limit = (phase_q == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      period_q <= '0;
      count_q  <= '0;
      phase_q  <= '0;
      flash_q  <= '0;
      bstate_q <= B_ON;
      duty_q   <= '0;
      dir_up_q <= 1'b1;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      flash_q  <= flash_d;
      bstate_q <= bstate_d;
      duty_q   <= duty_d;
      dir_up_q <= dir_up_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    count_d  = count_q;
    phase_d  = phase_q;
    flash_d  = flash_q;
    bstate_d = bstate_q;
    duty_d   = duty_q;
    dir_up_d = dir_up_q;
    led_d    = led_q;
    // A write reloads everything and swallows a coincident tick.
    if (we) begin
      mode_d   = decode_mode(mode);
      period_d = (period == 16'd0) ? 16'd1 : period;
      count_d  = (count == 4'd0) ? 4'd1 : count;
      phase_d  = '0;
      flash_d  = '0;
      bstate_d = B_ON;
      duty_d   = '0;
      dir_up_d = 1'b1;
      led_d    = (decode_mode(mode) == MODE_ON) || (decode_mode(mode) == MODE_BLINK) ||
                 (decode_mode(mode) == MODE_BURST);
    end else begin
      case (mode_q)
        MODE_ON: led_d = 1'b1;
        MODE_BLINK: begin
          if (tick) begin
            phase_d = at_limit ? 18'd0 : phase_q + 18'd1;
            if (at_limit) led_d = ~led_q;
          end
        end
        MODE_BURST: begin
          if (tick) begin
            phase_d = at_limit ? 18'd0 : phase_q + 18'd1;
            if (at_limit) begin
              case (bstate_q)
                B_ON: begin
                  bstate_d = B_OFF;
                  led_d    = 1'b0;
                  flash_d  = flash_q + 4'd1;
                end
                B_OFF: begin
                  if (flash_q < count_q) begin
                    bstate_d = B_ON;
                    led_d    = 1'b1;
                  end else begin
                    bstate_d = B_GAP;
                    led_d    = 1'b0;
                    flash_d  = '0;
                  end
                end
                default: begin
                  bstate_d = B_ON;
                  led_d    = 1'b1;
                end
              endcase
            end
          end
        end
        MODE_BREATHE: begin
          led_d = (pwm_cnt < duty_q);
          if (tick) begin
            phase_d = at_limit ? 18'd0 : phase_q + 18'd1;
            // Endpoints bounce straight back so no duty value is held twice.
            if (at_limit) begin
              if (dir_up_q) begin
                if (duty_q == DUTY_MAX) begin
                  duty_d   = DUTY_MAX - DUTY_ONE;
                  dir_up_d = 1'b0;
                end else begin
                  duty_d = duty_q + DUTY_ONE;
                end
              end else begin
                if (duty_q == '0) begin
                  duty_d   = DUTY_ONE;
                  dir_up_d = 1'b1;
                end else begin
                  duty_d = duty_q - DUTY_ONE;
                end
              end
            end
          end
        end
        default: led_d = 1'b0;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared 1 ms prescaler and PWM counter
// feeding independent per-channel pattern engines.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int NUM_CH      = 4,
  parameter int PWM_BITS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  led_pattern_gen_if.slave  cfg,
  output logic [NUM_CH-1:0] led
);

  localparam int unsigned DIV   = tick_div(CLK_FREQ_HZ);
  localparam int          PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int          CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRE_W-1:0]    presc;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;

  assign tick = (presc == PRE_W'(DIV - 1));

  // Free-running; config writes deliberately never touch the prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= tick ? '0 : presc + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_ch;
    assign we_ch = cfg.we && (cfg.ch == CH_W'(i));

    led_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .we      (we_ch),
      .mode    (cfg.mode),
      .period  (cfg.period_ms),
      .count   (cfg.count),
      .led     (led[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised bench for led_pattern_gen; expected LED levels come from a
// tick-count model of each pattern rather than from the channel state machine.
module tb_led_pattern_gen;

  localparam int NCH  = 3;
  localparam int DIVC = 10;
  localparam int PWMN = 16;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] led;

  led_pattern_gen_if #(.NUM_CH(NCH)) cfg_bus ();

  led_pattern_gen #(
    .CLK_FREQ_HZ (10000),
    .NUM_CH      (NCH),
    .PWM_BITS    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cfg (cfg_bus),
    .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int ecnt;
  int m_mode [NCH];
  int m_p    [NCH];
  int m_n    [NCH];
  int m_k    [NCH];
  logic [NCH-1:0] exp_led;

  // BLINK/BURST level after k ticks since the write.
  function automatic logic pattern_level(input int md, input int p, input int n, input int k);
    int len;
    int pos;
    if (md == 2) return ((k / p) % 2) == 0;
    len = 2 * p * n + 4 * p;
    pos = k % len;
    return (pos < 2 * p * n) && (((pos / p) % 2) == 0);
  endfunction

  // Triangle 0..15..1 repeating, one step per P ticks.
  function automatic int tri_duty(input int p, input int k);
    int s;
    s = (k / p) % 30;
    return (s <= 15) ? s : 30 - s;
  endfunction

  task automatic model_reset();
    ecnt = 0;
    exp_led = '0;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_p[c] = 1; m_n[c] = 1; m_k[c] = 0;
    end
  endtask

  // Processes the posedge that just passed, using the config still on the bus.
  task automatic model_step();
    int md;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_bus.we && int'(cfg_bus.ch) == c) begin
        md = (int'(cfg_bus.mode) > 4) ? 0 : int'(cfg_bus.mode);
        m_mode[c]  = md;
        m_p[c]     = (cfg_bus.period_ms == 0) ? 1 : int'(cfg_bus.period_ms);
        m_n[c]     = (cfg_bus.count == 0) ? 1 : int'(cfg_bus.count);
        m_k[c]     = 0;
        exp_led[c] = (md == 1) || (md == 2) || (md == 3);
      end else begin
        if (m_mode[c] == 4) exp_led[c] = ((ecnt % PWMN) < tri_duty(m_p[c], m_k[c]));
        if (ecnt % DIVC == DIVC - 1) m_k[c]++;
        if (m_mode[c] == 2 || m_mode[c] == 3)
          exp_led[c] = pattern_level(m_mode[c], m_p[c], m_n[c], m_k[c]);
        else if (m_mode[c] == 1) exp_led[c] = 1'b1;
        else if (m_mode[c] == 0) exp_led[c] = 1'b0;
      end
    end
    ecnt++;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!rst) model_step();
  endtask

  task automatic set_write(input int ch, input int md, input int per, input int cnt);
    cfg_bus.we        = 1'b1;
    cfg_bus.ch        = 2'(ch);
    cfg_bus.mode      = 3'(md);
    cfg_bus.period_ms = 16'(per);
    cfg_bus.count     = 4'(cnt);
  endtask

  task automatic clear_write();
    cfg_bus.we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_write();
    model_reset();
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (led !== 3'b000) begin
        n_err++;
        $display("[TB] FAIL reset_hold led=%b expected=000", led);
      end
    end
    rst = 1'b0;
    repeat (500) begin
      cycle();
      n_cmp++;
      if (led !== 3'b000) begin
        n_err++;
        $display("[TB] FAIL idle_led t=%0t led=%b expected=000", $time, led);
      end
      n_cmp++;
      if (dut.tick !== (ecnt % DIVC == DIVC - 1)) begin
        n_err++;
        $display("[TB] FAIL tick_pulse t=%0t tick=%b expected=%b", $time, dut.tick,
                 (ecnt % DIVC == DIVC - 1));
      end
    end
  endtask

  task automatic test_blink();
    repeat ($urandom_range(0, 9)) cycle();
    set_write(0, 2, 3, 0);
    repeat (150) begin
      cycle();
      clear_write();
      n_cmp++;
      if (led !== exp_led) begin
        n_err++;
        $display("[TB] FAIL blink t=%0t led=%b expected=%b", $time, led, exp_led);
      end
    end
  endtask

  task automatic test_burst();
    repeat ($urandom_range(0, 9)) cycle();
    set_write(1, 3, 2, 3);
    repeat (250) begin
      cycle();
      clear_write();
      n_cmp++;
      if (led !== exp_led) begin
        n_err++;
        $display("[TB] FAIL burst t=%0t led=%b expected=%b", $time, led, exp_led);
      end
    end
  endtask

  task automatic test_breathe();
    repeat ($urandom_range(0, 9)) cycle();
    set_write(2, 4, 1, 0);
    repeat (330) begin
      cycle();
      clear_write();
      n_cmp++;
      if (led !== exp_led) begin
        n_err++;
        $display("[TB] FAIL breathe t=%0t led=%b expected=%b", $time, led, exp_led);
      end
    end
  endtask

  task automatic test_async_reset();
    repeat ($urandom_range(1, 20)) cycle();
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (led !== 3'b000) begin
      n_err++;
      $display("[TB] FAIL async_reset t=%0t led=%b expected=000", $time, led);
    end
    repeat (3) cycle();
    rst = 1'b0;
    repeat (100) begin
      cycle();
      n_cmp++;
      if (led !== 3'b000) begin
        n_err++;
        $display("[TB] FAIL post_reset_off t=%0t led=%b expected=000", $time, led);
      end
    end
  endtask

  task automatic test_edge_cases();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle();
      if (ecnt % DIVC == DIVC - 1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("[TB] FAIL tick_align found=0 expected=1");
    end
    set_write(0, 2, 1, 0);
    for (int step = 0; step < 5; step++) begin
      repeat (40) begin
        cycle();
        clear_write();
        n_cmp++;
        if (led !== exp_led) begin
          n_err++;
          $display("[TB] FAIL edge_case%0d t=%0t led=%b expected=%b", step, $time, led, exp_led);
        end
      end
      case (step)
        0: set_write(3, 1, 1, 1);
        1: set_write(1, 6, 2, 2);
        2: set_write(2, 2, 0, 0);
        3: set_write(0, 3, 1, 0);
        default: clear_write();
      endcase
    end
    repeat (80) begin
      cycle();
      clear_write();
      n_cmp++;
      if (led !== exp_led) begin
        n_err++;
        $display("[TB] FAIL edge_n0 t=%0t led=%b expected=%b", $time, led, exp_led);
      end
    end
  endtask

  task automatic test_random();
    int gap;
    repeat (30) begin
      set_write($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 3));
      gap = $urandom_range(1, 80);
      repeat (gap) begin
        cycle();
        clear_write();
        n_cmp++;
        if (led !== exp_led) begin
          n_err++;
          $display("[TB] FAIL random t=%0t led=%b expected=%b", $time, led, exp_led);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_bus.we        = 1'b0;
    cfg_bus.ch        = '0;
    cfg_bus.mode      = '0;
    cfg_bus.period_ms = '0;
    cfg_bus.count     = '0;
    test_reset();
    test_blink();
    test_burst();
    test_breathe();
    test_async_reset();
    test_edge_cases();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
